alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 instr_valid  input  1  instruction word available on instr.
REQ-005 instr  input  32  instruction; opcode = [31:26], funct = [5:0].
REQ-006 instr_ready  output  1  high only in IDLE; instruction accepted when instr_valid & instr_ready.
REQ-007 beq_taken  input  1  ALU branch-equal result (zero flag gated by beq_inst), valid in EXECUTE.
REQ-008 mem_ready  input  1  data-memory access complete.
REQ-009 alu_op_ctrl  output  5  ALU operation code: 0 OR, 1 SHIFT-left, 2 XNOR, 3 NAND, 4 SUB, 5 ADD.
REQ-010 alu_control  output  1  ALU enable; high only in EXECUTE.
REQ-011 beq_inst  output  1  branch compare active; high only in EXECUTE of BEQ.
REQ-012 alu_src_imm  output  1  second ALU operand is the sign-extended immediate (ADDI/LW/SW).
REQ-013 mem_read, mem_write  output  1 each  memory strobes, held through MEM until mem_ready.
REQ-014 reg_write  output  1  one-cycle register-file write strobe in WRITEBACK.
REQ-015 pc_write, pc_src  output  1 each  PC update pulse; pc_src=1 selects branch target.
REQ-016 done  output  1  one-cycle pulse when an instruction retires.
REQ-017 illegal  output  1  one-cycle pulse when an undecodable instruction is dropped.

Function
REQ-018 States SHALL be IDLE, DECODE, EXECUTE, MEM, WRITEBACK; outputs Moore-decoded from state plus the latched instruction register.
REQ-019 On acceptance in IDLE the instruction SHALL be latched and the state SHALL go to DECODE; instr is ignored elsewhere.
REQ-020 Decode table: opcode 0x00 with funct[5:3]=0 and funct[2:0] in 0..5 -> R-type, alu_op_ctrl=funct[2:0]; 0x08 ADDI -> ADD, imm; 0x23 LW -> ADD, imm; 0x2B SW -> ADD, imm; 0x04 BEQ -> SUB.
REQ-021 Any other opcode/funct SHALL pulse illegal in DECODE, go to IDLE, and never assert alu_control; codes 6-31 SHALL never be driven on alu_op_ctrl.
REQ-022 Transitions: R-type/ADDI: DECODE->EXECUTE->WRITEBACK->IDLE (accept-to-done 3 cycles after acceptance edge).
REQ-023 BEQ: DECODE->EXECUTE->IDLE; in EXECUTE pc_write=1, pc_src=beq_taken, done=1, no reg_write.
REQ-024 LW: DECODE->EXECUTE->MEM (mem_read held until mem_ready)->WRITEBACK->IDLE.
REQ-025 SW: DECODE->EXECUTE->MEM (mem_write held until mem_ready)->IDLE with done in the mem_ready cycle.
REQ-026 Non-branch instructions SHALL pulse pc_write with pc_src=0 in the cycle done is asserted.
REQ-027 mem_ready asserted in the first MEM cycle SHALL complete MEM in one cycle; mem_ready outside MEM SHALL be ignored.
REQ-028 Outside EXECUTE alu_op_ctrl SHALL be 0 and alu_control 0.
REQ-029 instr_valid in the same cycle done is asserted SHALL NOT be accepted (ready only in IDLE).

Reset
REQ-030 rst SHALL force IDLE and discard the latched instruction, including mid-MEM (strobes drop next cycle).
REQ-031 Reset values: instr_ready=1, all other outputs 0, alu_op_ctrl=0.

Structure
REQ-032 Opcode/funct constants, ALU code constants, and the state enumeration SHALL live in a shared package/header alu_seq_pkg.
REQ-033 Decode SHALL be a combinational sub-module alu_seq_decode (instr -> class, alu code, imm select, legal).

Verification
REQ-034 R-type funct 0x02 -> EXECUTE: alu_op_ctrl=2, alu_control=1; reg_write and done 1 cycle later.
REQ-035 BEQ with beq_taken=1 -> EXECUTE: alu_op_ctrl=4, beq_inst=1, pc_write=1, pc_src=1, done=1; with 0 -> pc_src=0.
REQ-036 LW with mem_ready delayed 3 cycles -> mem_read high 4 MEM cycles, then reg_write/done.
REQ-037 Opcode 0x3F or R-type funct 0x07 -> illegal pulse in DECODE, alu_control never 1, back to IDLE.
REQ-038 rst during SW MEM wait -> next cycle IDLE, mem_write=0, instr_ready=1, no done.
REQ-039 Back-to-back instr_valid held high -> second instruction accepted only in the cycle after return to IDLE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU sequencer: opcodes, ALU operation codes,
// FSM states and instruction classes.
package alu_seq_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [4:0] ALU_OR   = 5'd0;
  localparam logic [4:0] ALU_SHL  = 5'd1;
  localparam logic [4:0] ALU_XNOR = 5'd2;
  localparam logic [4:0] ALU_NAND = 5'd3;
  localparam logic [4:0] ALU_SUB  = 5'd4;
  localparam logic [4:0] ALU_ADD  = 5'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEM,
    ST_WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ADDI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ILLEGAL
  } instr_class_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: opcode/funct to instruction class,
// ALU operation code, immediate-operand select and legality.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0]   i_opcode,
  input  logic [5:0]   i_funct,
  output instr_class_t o_class,
  output logic [4:0]   o_alu_code,
  output logic         o_imm_sel,
  output logic         o_legal
);

  always_comb begin
    o_class    = CLS_ILLEGAL;
    o_alu_code = ALU_OR;
    o_imm_sel  = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        // only funct 0..5 map onto real ALU operations
        if (i_funct[5:3] == 3'b000 && i_funct[2:0] <= 3'd5) begin
          o_class    = CLS_RTYPE;
          o_alu_code = {2'b00, i_funct[2:0]};
        end
      end
      OP_ADDI: begin
        o_class    = CLS_ADDI;
        o_alu_code = ALU_ADD;
        o_imm_sel  = 1'b1;
      end
      OP_LW: begin
        o_class    = CLS_LW;
        o_alu_code = ALU_ADD;
        o_imm_sel  = 1'b1;
      end
      OP_SW: begin
        o_class    = CLS_SW;
        o_alu_code = ALU_ADD;
        o_imm_sel  = 1'b1;
      end
      OP_BEQ: begin
        o_class    = CLS_BEQ;
        o_alu_code = ALU_SUB;
      end
      default: ;
    endcase
  end

  assign o_legal = (o_class != CLS_ILLEGAL);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU/memory control sequencer for a single-issue datapath.
//
// state        | meaning
// ST_IDLE      | ready for a new instruction
// ST_DECODE    | latched instruction decoded; illegal ones dropped here
// ST_EXECUTE   | ALU enabled; BEQ resolves and retires here
// ST_MEM       | LW/SW strobe held until mem_ready; SW retires here
// ST_WRITEBACK | register write and retire for R-type/ADDI/LW
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        beq_taken,
  input  logic        mem_ready,
  output logic [4:0]  alu_op_ctrl,
  output logic        alu_control,
  output logic        beq_inst,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        done,
  output logic        illegal
);

  state_t       r_state;
  logic [5:0]   r_opcode;
  logic [5:0]   r_funct;
  instr_class_t w_class;
  logic [4:0]   w_alu_code;
  logic         w_imm_sel;
  logic         w_legal;
  logic         w_in_exec;
  logic         w_in_mem;
  logic         w_unused_fields;

  // register/immediate fields are consumed by the datapath, not here
  assign w_unused_fields = ^instr[25:6];

  alu_seq_decode u_decode (
    .i_opcode   (r_opcode),
    .i_funct    (r_funct),
    .o_class    (w_class),
    .o_alu_code (w_alu_code),
    .o_imm_sel  (w_imm_sel),
    .o_legal    (w_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_opcode <= '0;
      r_funct  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_opcode <= instr[31:26];
            r_funct  <= instr[5:0];
            r_state  <= ST_DECODE;
          end
        end
        ST_DECODE: r_state <= w_legal ? ST_EXECUTE : ST_IDLE;
        ST_EXECUTE: begin
          case (w_class)
            CLS_BEQ:        r_state <= ST_IDLE;
            CLS_LW, CLS_SW: r_state <= ST_MEM;
            default:        r_state <= ST_WRITEBACK;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) r_state <= (w_class == CLS_LW) ? ST_WRITEBACK : ST_IDLE;
        end
        ST_WRITEBACK: r_state <= ST_IDLE;
        default:      r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_exec = (r_state == ST_EXECUTE);
  assign w_in_mem  = (r_state == ST_MEM);

  assign instr_ready = (r_state == ST_IDLE);
  assign alu_control = w_in_exec;
  assign alu_op_ctrl = w_in_exec ? w_alu_code : ALU_OR;
  assign alu_src_imm = w_in_exec & w_imm_sel;
  assign beq_inst    = w_in_exec & (w_class == CLS_BEQ);
  assign mem_read    = w_in_mem & (w_class == CLS_LW);
  assign mem_write   = w_in_mem & (w_class == CLS_SW);
  assign reg_write   = (r_state == ST_WRITEBACK);
  assign illegal     = (r_state == ST_DECODE) & ~w_legal;
  // retire points: writeback, branch execute, or store completion
  assign done        = reg_write | beq_inst | (mem_write & mem_ready);
  assign pc_write    = done;
  assign pc_src      = beq_inst & beq_taken;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer: stimulus pushes expected
// retire records, a negedge monitor pops and compares them.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        beq_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        instr_ready;
  logic [4:0]  alu_op_ctrl;
  logic        alu_control, beq_inst, alu_src_imm, mem_read, mem_write;
  logic        reg_write, pc_write, pc_src, done, illegal;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .beq_taken   (beq_taken),
    .mem_ready   (mem_ready),
    .alu_op_ctrl (alu_op_ctrl),
    .alu_control (alu_control),
    .beq_inst    (beq_inst),
    .alu_src_imm (alu_src_imm),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ill;
    int lat;
    int alu;
    int imm;
    int beq;
    int regw;
    int rd;
    int wr;
    int nexec;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cur_delay = 0;
  int   beq_mode = 0;
  bit   outstanding = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: retire behaviour straight from the decode table
  function automatic exp_t model(input logic [31:0] w, input int d);
    exp_t e;
    int op, fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    e.ill = 0; e.lat = 0; e.alu = 0; e.imm = 0; e.beq = 0;
    e.regw = 0; e.rd = 0; e.wr = 0; e.nexec = 1;
    if (op == 'h00 && fn < 6) begin
      e.alu = fn; e.lat = 3; e.regw = 1;
    end else if (op == 'h08) begin
      e.alu = 5; e.imm = 1; e.lat = 3; e.regw = 1;
    end else if (op == 'h23) begin
      e.alu = 5; e.imm = 1; e.lat = 4 + d; e.regw = 1; e.rd = d + 1;
    end else if (op == 'h2B) begin
      e.alu = 5; e.imm = 1; e.lat = 3 + d; e.wr = d + 1;
    end else if (op == 'h04) begin
      e.alu = 4; e.beq = 1; e.lat = 2;
    end else begin
      e.ill = 1; e.lat = 1; e.nexec = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] w;
    logic [5:0]  op;
    logic [5:0]  fn;
    w  = $urandom;
    fn = w[5:0];
    case (kind)
      0: begin op = 6'h00; fn = 6'($urandom_range(0, 5)); end
      1: op = 6'h08;
      2: op = 6'h23;
      3: op = 6'h2B;
      4: op = 6'h04;
      5: begin
        op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'($urandom);
        while (op == 6'h00 || op == 6'h08 || op == 6'h23 || op == 6'h2B || op == 6'h04)
          op = op + 6'd1;
      end
      default: begin
        op = 6'h00;
        if ($urandom_range(0, 1) == 1) fn = {3'($urandom_range(1, 7)), 3'($urandom)};
        else fn = {3'b000, 3'($urandom_range(6, 7))};
      end
    endcase
    w[31:26] = op;
    w[5:0]   = fn;
    return w;
  endfunction

  // memory responder: completes after cur_delay wait cycles, random noise elsewhere
  int mem_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (mem_read || mem_write) begin
      mem_cnt++;
      mem_ready = (mem_cnt > cur_delay);
    end else begin
      mem_cnt = 0;
      mem_ready = 1'($urandom_range(0, 1));
    end
    beq_taken = (beq_mode == 0) ? 1'($urandom_range(0, 1)) : (beq_mode == 1);
  end

  // monitor
  int cyc = 0;
  int start_cyc = 0;
  bit was_rst = 0;
  int n_exec, alu_seen, imm_seen, beq_seen, n_rd, n_wr, n_regw;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      if (outstanding) chk("done_during_reset", int'(done), 0);
      sb.delete();
      outstanding = 0;
      was_rst = 1;
    end else begin
      if (was_rst) begin
        chk("reset_outputs",
            int'({instr_ready, alu_op_ctrl, alu_control, beq_inst, alu_src_imm, mem_read,
                  mem_write, reg_write, pc_write, pc_src, done, illegal}), 'h8000);
        was_rst = 0;
      end
      chk("instr_ready", int'(instr_ready), int'(!outstanding));
      if (!alu_control) chk("alu_op_idle", int'(alu_op_ctrl), 0);
      chk("pc_write_eq_done", int'(pc_write), int'(done));
      if (outstanding) begin
        if (alu_control) begin
          n_exec++;
          alu_seen = int'(alu_op_ctrl);
        end
        imm_seen += int'(alu_src_imm);
        beq_seen += int'(beq_inst);
        n_rd     += int'(mem_read);
        n_wr     += int'(mem_write);
        n_regw   += int'(reg_write);
      end
      if (done || illegal) begin
        if (sb.size() == 0) begin
          chk("unexpected_retire", int'(done || illegal), 0);
        end else begin
          e = sb.pop_front();
          chk("illegal_flag", int'(illegal), int'(e.ill));
          chk("done_flag", int'(done), int'(!e.ill));
          chk("latency", cyc - start_cyc, e.lat);
          chk("exec_cycles", n_exec, e.nexec);
          if (e.nexec != 0) chk("alu_op", alu_seen, e.alu);
          chk("imm_cycles", imm_seen, e.imm);
          chk("beq_cycles", beq_seen, e.beq);
          chk("mem_read_cycles", n_rd, e.rd);
          chk("mem_write_cycles", n_wr, e.wr);
          chk("reg_write_cycles", n_regw, e.regw);
          chk("pc_src", int'(pc_src), e.beq ? int'(beq_taken) : 0);
        end
        outstanding = 0;
      end
      if (instr_valid && instr_ready) begin
        outstanding = 1;
        start_cyc = cyc;
        n_exec = 0; alu_seen = 0; imm_seen = 0; beq_seen = 0;
        n_rd = 0; n_wr = 0; n_regw = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] w, input int d, input bit keep_valid);
    int n;
    n = 0;
    cur_delay = d;
    instr = w;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!(instr_ready && !rst) && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) chk("accept_timeout", int'(instr_ready), 1);
    else sb.push_back(model(w, d));
    @(posedge clk); #1;
    if (!keep_valid) instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (outstanding && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", int'(outstanding), 0);
  endtask

  initial begin
    int kind, d, len, n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, d, len, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    issue({6'h00, 20'h12345, 6'h02}, 0, 0); wait_idle();
    beq_mode = 1; issue({6'h04, 26'h0}, 0, 0); wait_idle();
    beq_mode = 2; issue({6'h04, 26'h0}, 0, 0); wait_idle();
    beq_mode = 0;
    issue({6'h23, 26'h0}, 3, 0); wait_idle();
    issue({6'h2B, 26'h0}, 0, 0); wait_idle();
    issue({6'h3F, 26'h0}, 0, 0); wait_idle();
    issue({6'h00, 20'h0, 6'h07}, 0, 0); wait_idle();

    // reset while a store waits on memory
    issue({6'h2B, 26'h155}, 20, 0);
    n = 0;
    while (!mem_write && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sw_reached_mem", int'(mem_write), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wait_idle();

    // back-to-back with instr_valid held high
    issue({6'h08, 26'h3}, 0, 1);
    issue({6'h00, 20'h0, 6'h05}, 0, 1);
    issue({6'h3F, 26'h0}, 0, 1);
    issue({6'h00, 20'h0, 6'h01}, 0, 0);
    wait_idle();

    // random single issues
    for (int i = 0; i < 160; i++) begin
      kind = $urandom_range(0, 6);
      d = $urandom_range(0, 4);
      issue(rand_instr(kind), d, 0);
      wait_idle();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // random bursts of non-memory, non-branch instructions
    for (int b = 0; b < 8; b++) begin
      len = $urandom_range(2, 5);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(0, 3))
          0: kind = 0;
          1: kind = 1;
          2: kind = 5;
          default: kind = 6;
        endcase
        issue(rand_instr(kind), 0, j < len - 1);
      end
      wait_idle();
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
